riscv_core_imem_resp_queue: RTL and testbench

RISCV_CORE_IMEM_RESP_QUEUE -- requirements
Module: riscv_CoreImemRespQueue

---
 rtl/riscv_core_imem_resp_queue.sv | 140 ++++++++++++++
 tb/tb_riscv_core_imem_resp_queue.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_imem_resp_queue.sv
// Instruction-memory response queue between the fetch stage and decode.
// Optional macro RISCV_IMEMQ_BYPASS_EN adds a 0-cycle bypass from an empty queue.
module riscv_core_imem_resp_queue #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     imemreq_val,
  input  logic                     imemreq_rdy,
  output logic                     imemreq_allow,
  input  logic                     imemresp_val,
  input  logic [31:0]              imemresp_msg_data,
  input  logic                     squash,
  output logic                     inst_val,
  output logic [31:0]              inst_data,
  input  logic                     inst_rdy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // One spare bit: a redirect may fire while the window is already full.
  localparam int OW = CW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;
  logic          proto_err_q, proto_err_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];

  logic          req_fire;
  logic          resp_stray;
  logic          resp_ok;
  logic          resp_drop;
  logic          resp_take;
  logic          fifo_nonempty;
  logic          fifo_full;
  logic          bypass;
  logic [31:0]   bypass_data;
  logic          deq;
  logic          enq;
  logic          overflow;

  always_comb begin
    req_fire      = imemreq_val & imemreq_rdy;
    resp_stray    = imemresp_val & (out_cnt_q == '0);
    resp_ok       = imemresp_val & ~resp_stray;
    resp_drop     = resp_ok & (squash | (drop_cnt_q != '0));
    resp_take     = resp_ok & ~resp_drop;
    fifo_nonempty = (count_q != '0);
    fifo_full     = (count_q == CW'(DEPTH));

`ifdef RISCV_IMEMQ_BYPASS_EN
    bypass      = resp_take & ~fifo_nonempty;
    bypass_data = imemresp_msg_data;
`else
    bypass      = 1'b0;
    bypass_data = 32'h0;
`endif

    inst_val  = ~squash & (fifo_nonempty | bypass);
    inst_data = 32'h0;
    if (inst_val) begin
      inst_data = fifo_nonempty ? mem_q[rd_ptr_q] : bypass_data;
    end

    deq      = inst_val & inst_rdy & fifo_nonempty;
    // A bypassed word consumed this cycle never touches storage.
    enq      = resp_take & ~(bypass & inst_rdy) & (~fifo_full | deq);
    overflow = resp_take & ~(bypass & inst_rdy) & fifo_full & ~deq;

    mem_d = mem_q;
    if (enq) begin
      mem_d[wr_ptr_q] = imemresp_msg_data;
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (squash) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end

    out_cnt_d = out_cnt_q + OW'(req_fire) - OW'(resp_ok);

    // Every fetch still in flight at a redirect is stale, except the redirect
    // target itself and the response retired in this very cycle.
    drop_cnt_d = drop_cnt_q;
    if (squash) begin
      drop_cnt_d = out_cnt_q - OW'(resp_ok);
    end else if (resp_ok && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - OW'(1);
    end

    proto_err_d = proto_err_q | resp_stray | overflow;

    imemreq_allow = (({1'b0, out_cnt_q} + (OW + 1)'(count_q)) < (OW + 1)'(DEPTH));
    count         = count_q;
    proto_err     = proto_err_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_cnt_q   <= out_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        mem_q[gi] <= 32'h0;
      end else begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_imem_resp_queue.sv
// Directed bench for riscv_core_imem_resp_queue (DEPTH = 2); expectations
// follow RISCV_IMEMQ_BYPASS_EN when the bench is built with that macro.
module tb_riscv_core_imem_resp_queue;

  logic        clk;
  logic        reset_n;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic        imemreq_allow;
  logic        imemresp_val;
  logic [31:0] imemresp_msg_data;
  logic        squash;
  logic        inst_val;
  logic [31:0] inst_data;
  logic        inst_rdy;
  logic [1:0]  count;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

`ifdef RISCV_IMEMQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  riscv_core_imem_resp_queue #(.DEPTH(2)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .imemreq_val       (imemreq_val),
    .imemreq_rdy       (imemreq_rdy),
    .imemreq_allow     (imemreq_allow),
    .imemresp_val      (imemresp_val),
    .imemresp_msg_data (imemresp_msg_data),
    .squash            (squash),
    .inst_val          (inst_val),
    .inst_data         (inst_data),
    .inst_rdy          (inst_rdy),
    .count             (count),
    .proto_err         (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("chk %s ok (%h)", tag, got);
    end
  endtask

  // Advance one edge, then settle so the next inputs sit away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imemreq_val       = 1'b0;
    imemreq_rdy       = 1'b0;
    imemresp_val      = 1'b0;
    imemresp_msg_data = 32'h0;
    squash            = 1'b0;
    inst_rdy          = 1'b0;
  endtask

  task automatic fire();
    idle();
    imemreq_val = 1'b1;
    imemreq_rdy = 1'b1;
    tick();
  endtask

  task automatic resp(input logic [31:0] d, input logic rdy);
    idle();
    imemresp_val      = 1'b1;
    imemresp_msg_data = d;
    inst_rdy          = rdy;
    tick();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst_inst_val", 32'(inst_val), 32'd0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_allow", 32'(imemreq_allow), 32'd1);
    chk("rst_proto_err", 32'(proto_err), 32'd0);

    // Single fetch latency
    idle();
    imemreq_val = 1'b1;
    imemreq_rdy = 1'b1;
    #1;
    chk("lat_allow", 32'(imemreq_allow), 32'd1);
    tick();
    idle();
    imemresp_val      = 1'b1;
    imemresp_msg_data = 32'h00000013;
    inst_rdy          = 1'b1;
    #1;
    chk("lat_c1_val", 32'(inst_val), BYP ? 32'd1 : 32'd0);
    chk("lat_c1_data", inst_data, BYP ? 32'h13 : 32'h0);
    tick();
    idle();
    inst_rdy = 1'b1;
    #1;
    chk("lat_c2_count", 32'(count), BYP ? 32'd0 : 32'd1);
    chk("lat_c2_val", 32'(inst_val), BYP ? 32'd0 : 32'd1);
    chk("lat_c2_data", inst_data, BYP ? 32'h0 : 32'h13);
    tick();
    idle();
    #1;
    chk("lat_c3_count", 32'(count), 32'd0);

    // Credit limit at DEPTH = 2
    fire();
    #1;
    chk("cred_allow_1out", 32'(imemreq_allow), 32'd1);
    fire();
    idle();
    #1;
    chk("cred_allow_2out", 32'(imemreq_allow), 32'd0);
    resp(32'h111, 1'b0);
    resp(32'h222, 1'b0);
    idle();
    #1;
    chk("cred_count_full", 32'(count), 32'd2);
    chk("cred_allow_full", 32'(imemreq_allow), 32'd0);
    chk("cred_head", inst_data, 32'h111);
    inst_rdy = 1'b1;
    tick();
    idle();
    #1;
    chk("cred_count_1", 32'(count), 32'd1);
    chk("cred_allow_after_deq", 32'(imemreq_allow), 32'd1);
    chk("cred_head2", inst_data, 32'h222);
    inst_rdy = 1'b1;
    tick();
    idle();
    #1;
    chk("cred_drained", 32'(count), 32'd0);

    // Full queue: simultaneous enqueue and dequeue, pointer wrap
    fire();
    fire();
    resp(32'hA1, 1'b0);
    resp(32'hA2, 1'b0);
    idle();
    #1;
    chk("wrap_allow_full", 32'(imemreq_allow), 32'd0);
    fire();
    idle();
    imemresp_val      = 1'b1;
    imemresp_msg_data = 32'hA3;
    inst_rdy          = 1'b1;
    #1;
    chk("wrap_head_a1", inst_data, 32'hA1);
    tick();
    idle();
    #1;
    chk("wrap_count_held", 32'(count), 32'd2);
    chk("wrap_head_a2", inst_data, 32'hA2);
    inst_rdy = 1'b1;
    tick();
    #1;
    chk("wrap_head_a3", inst_data, 32'hA3);
    tick();
    idle();
    #1;
    chk("wrap_drained", 32'(count), 32'd0);
    chk("wrap_err_clean", 32'(proto_err), 32'd0);

    // Squash with two outstanding and a redirect fetch in the same cycle
    fire();
    fire();
    idle();
    squash      = 1'b1;
    imemreq_val = 1'b1;
    imemreq_rdy = 1'b1;
    #1;
    chk("sq_inst_val", 32'(inst_val), 32'd0);
    tick();
    resp(32'hDEAD0001, 1'b0);
    idle();
    #1;
    chk("sq_drop1", 32'(count), 32'd0);
    chk("sq_drop1_val", 32'(inst_val), 32'd0);
    resp(32'hDEAD0002, 1'b0);
    idle();
    #1;
    chk("sq_drop2", 32'(count), 32'd0);
    idle();
    imemresp_val      = 1'b1;
    imemresp_msg_data = 32'h0000006F;
    #1;
    chk("sq_target_c0", 32'(inst_val), BYP ? 32'd1 : 32'd0);
    tick();
    idle();
    #1;
    chk("sq_target_count", 32'(count), 32'd1);
    chk("sq_target_data", inst_data, 32'h6F);
    inst_rdy = 1'b1;
    tick();
    idle();
    #1;
    chk("sq_target_drained", 32'(count), 32'd0);

    // Squash while full with a response landing in the squash cycle
    fire();
    fire();
    resp(32'hB1, 1'b0);
    resp(32'hB2, 1'b0);
    fire();
    fire();
    idle();
    squash            = 1'b1;
    imemresp_val      = 1'b1;
    imemresp_msg_data = 32'hC1;
    #1;
    chk("sqf_inst_val", 32'(inst_val), 32'd0);
    tick();
    idle();
    #1;
    chk("sqf_count", 32'(count), 32'd0);
    chk("sqf_val_next", 32'(inst_val), 32'd0);
    resp(32'hC2, 1'b0);
    idle();
    #1;
    chk("sqf_c2_dropped", 32'(count), 32'd0);
    chk("sqf_allow", 32'(imemreq_allow), 32'd1);
    fire();
    resp(32'h77, 1'b0);
    idle();
    #1;
    chk("sqf_new_count", 32'(count), 32'd1);
    chk("sqf_new_data", inst_data, 32'h77);
    inst_rdy = 1'b1;
    tick();
    idle();
    #1;
    chk("sqf_err_clean", 32'(proto_err), 32'd0);

    // Stray response
    resp(32'hBAD, 1'b0);
    idle();
    #1;
    chk("stray_err", 32'(proto_err), 32'd1);
    chk("stray_count", 32'(count), 32'd0);
    chk("stray_allow", 32'(imemreq_allow), 32'd1);
    tick();
    #1;
    chk("stray_err_held", 32'(proto_err), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst2_err", 32'(proto_err), 32'd0);
    chk("rst2_count", 32'(count), 32'd0);
    chk("rst2_allow", 32'(imemreq_allow), 32'd1);
    chk("rst2_inst_val", 32'(inst_val), 32'd0);
    chk("rst2_inst_data", inst_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
